// File: rtl/bcd_seg_pkg.sv
// Shared definitions for bcd_seg_scanner: scan states, active-high 7-segment
// glyphs {g,f,e,d,c,b,a} and the pin polarity helper.
package bcd_seg_pkg;

  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP1  = 2'd1,
    S_TENS  = 2'd2,
    S_GAP0  = 2'd3
  } scan_state_t;

  localparam logic [6:0] GLYPH_0    = 7'b0111111;
  localparam logic [6:0] GLYPH_1    = 7'b0000110;
  localparam logic [6:0] GLYPH_2    = 7'b1011011;
  localparam logic [6:0] GLYPH_3    = 7'b1001111;
  localparam logic [6:0] GLYPH_4    = 7'b1100110;
  localparam logic [6:0] GLYPH_5    = 7'b1101101;
  localparam logic [6:0] GLYPH_6    = 7'b1111101;
  localparam logic [6:0] GLYPH_7    = 7'b0000111;
  localparam logic [6:0] GLYPH_8    = 7'b1111111;
  localparam logic [6:0] GLYPH_9    = 7'b1101111;
  localparam logic [6:0] GLYPH_DASH = 7'b1000000;

  // Display pins packed as {an[1:0], dp, seg[6:0]}.
  localparam int unsigned PIN_W = 10;

  function automatic logic [PIN_W-1:0] pin_polarity(input logic [PIN_W-1:0] act,
                                                    input logic             active_low);
    return active_low ? ~act : act;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD to 7-segment decoder, active-high {g,f,e,d,c,b,a}; codes 10-15 show a dash.
module bcd_to_seg7
  import bcd_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = GLYPH_DASH;
    case (i_bcd)
      4'd0:    o_seg = GLYPH_0;
      4'd1:    o_seg = GLYPH_1;
      4'd2:    o_seg = GLYPH_2;
      4'd3:    o_seg = GLYPH_3;
      4'd4:    o_seg = GLYPH_4;
      4'd5:    o_seg = GLYPH_5;
      4'd6:    o_seg = GLYPH_6;
      4'd7:    o_seg = GLYPH_7;
      4'd8:    o_seg = GLYPH_8;
      4'd9:    o_seg = GLYPH_9;
      default: o_seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_seg_scanner.sv
// Two-digit multiplexed 7-segment scanner with tear-free digit shadowing and
// an overflow dp hold. Optional leading-zero blanking: BCD_SEG_LZB_EN.
module bcd_seg_scanner
  import bcd_seg_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 3000,
  parameter int unsigned GAP_DIV      = 16,
  parameter int unsigned OVF_FRAMES   = 200,
  parameter int unsigned COMMON_ANODE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_1,
  input  logic [3:0] digit_10,
  input  logic       carry,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] an,
  output logic       frame_tick
);

  localparam int unsigned      MAX_DIV   = (SCAN_DIV > GAP_DIV) ? SCAN_DIV : GAP_DIV;
  localparam int unsigned      CNT_W     = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_DIV - 1);
  localparam logic             ACT_LOW   = (COMMON_ANODE != 0);
  localparam logic [PIN_W-1:0] PINS_IDLE = pin_polarity('0, ACT_LOW);

  scan_state_t      r_state;
  scan_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_presc;
  logic [CNT_W-1:0] w_presc_nxt;
  logic             w_slot_end;
  logic [3:0]       r_sh1;
  logic [3:0]       r_sh10;
  logic [7:0]       r_hold;
  logic             r_frame_tick;
  logic [PIN_W-1:0] r_pins;
  logic             w_frame_start;
  logic [3:0]       w_dec_in;
  logic [6:0]       w_glyph;
  logic [1:0]       w_an;
  logic             w_dp;
  logic [6:0]       w_seg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_GAP0;
      r_presc <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
    end
  end

  assign w_dec_in = (r_state == S_TENS) ? r_sh10 : r_sh1;

  bcd_to_seg7 u_dec (
    .i_bcd (w_dec_in),
    .o_seg (w_glyph)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_slot_end  = 1'b0;
    w_an        = '0;
    w_seg       = '0;
    w_dp        = 1'b0;
    case (r_state)
      S_UNITS: begin
        w_slot_end = (r_presc == SCAN_LAST);
        if (w_slot_end) w_state_nxt = S_GAP1;
        w_an  = 2'b01;
        w_seg = w_glyph;
      end
      S_GAP1: begin
        w_slot_end = (r_presc == GAP_LAST);
        if (w_slot_end) w_state_nxt = S_TENS;
      end
      S_TENS: begin
        w_slot_end = (r_presc == SCAN_LAST);
        if (w_slot_end) w_state_nxt = S_GAP0;
        w_dp = (r_hold != '0);
`ifdef BCD_SEG_LZB_EN
        if (r_sh10 != 4'd0) begin
          w_an  = 2'b10;
          w_seg = w_glyph;
        end
`else
        w_an  = 2'b10;
        w_seg = w_glyph;
`endif
      end
      S_GAP0: begin
        w_slot_end = (r_presc == GAP_LAST);
        if (w_slot_end) w_state_nxt = S_UNITS;
      end
      default: w_state_nxt = S_GAP0;
    endcase
    w_presc_nxt = w_slot_end ? '0 : r_presc + 1'b1;
  end

  assign w_frame_start = (r_state == S_UNITS) && (r_presc == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sh1  <= '0;
      r_sh10 <= '0;
      r_hold <= '0;
    end else begin
      if ((r_state == S_GAP0) && w_slot_end) begin
        r_sh1  <= digit_1;
        r_sh10 <= digit_10;
      end
      // Reload beats the per-frame decrement so a carry on a frame boundary keeps full frames.
      if (carry) begin
        r_hold <= 8'(OVF_FRAMES);
      end else if (r_frame_tick && (r_hold != '0)) begin
        r_hold <= r_hold - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame_tick <= 1'b0;
      r_pins       <= PINS_IDLE;
    end else begin
      r_frame_tick <= w_frame_start;
      r_pins       <= pin_polarity({w_an, w_dp, w_seg}, ACT_LOW);
    end
  end

  assign seg        = r_pins[6:0];
  assign dp         = r_pins[7];
  assign an         = r_pins[9:8];
  assign frame_tick = r_frame_tick;

endmodule
